// File: rtl/global_test_pkg.sv
// Shared types and constants for the global-clock routing minitests.
// The PRBS7 definition here is reused by the carry-chain and DCS minitests.
package global_test_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        CHECK  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam logic [6:0] PRBS7_SEED   = 7'h7F;
    localparam int         PRBS7_TAP_HI = 6;
    localparam int         PRBS7_TAP_LO = 5;
    localparam int         MATCH_W      = 8;

    // Observation bundle for checkers: FSM state plus raw generator state.
    typedef struct packed {
        state_t     state;
        logic [6:0] lfsr;
    } dbg_t;

    // x^7 + x^6 + 1, shifting toward the MSB so that lfsr[6] is the output bit.
    function automatic logic [6:0] prbs7_next(input logic [6:0] s);
        return {s[5:0], s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO]};
    endfunction

endpackage

// File: rtl/prbs7_gen.sv
// PRBS7 generator with synchronous reseed and advance controls.
// load has priority over adv so a reseed always lands on the seed value.
module prbs7_gen
    import global_test_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       adv,
    output logic [6:0] lfsr
);

    logic [6:0] lfsr_q;
    logic [6:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = PRBS7_SEED;
        end else if (adv) begin
            lfsr_d = prbs7_next(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= PRBS7_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/global_prbs_tester.sv
// PRBS7 stimulus/response checker wrapped around the corner-to-corner register chain.
// Compares the chain output against a LATENCY-deep delayed copy of the stimulus.
module global_prbs_tester
    import global_test_pkg::*;
#(
    parameter int LATENCY    = 5,
    parameter int LOCK_COUNT = 32,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             a,
    input  logic             q,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output dbg_t             dbg_o
);

    localparam int FILL_W = $clog2(LATENCY + 1);

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(LATENCY - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);

    state_t             state_q;
    logic [FILL_W-1:0]  fill_cnt_q;
    logic [MATCH_W-1:0] match_cnt_q;
    logic               err_q;
    logic               locked_q;
    logic [ERR_W-1:0]   err_count_q;
    logic [LATENCY-1:0] dly_q;
    logic [LATENCY-1:0] dly_d;

    logic [6:0] lfsr;
    logic       gen_load;
    logic       gen_adv;
    logic       exp_bit;
    logic       mismatch;

    // Leaving any active state reseeds, so IDLE always presents the seed MSB on a.
    assign gen_load = (state_q != IDLE) && !en;
    assign gen_adv  = (state_q != IDLE);

    prbs7_gen u_prbs7_gen (
        .clk  (clk),
        .rst  (rst),
        .load (gen_load),
        .adv  (gen_adv),
        .lfsr (lfsr)
    );

    assign a = lfsr[6];

    // Expected-data delay mirrors a LATENCY-stage register chain fed by a.
    always_comb begin
        dly_d    = dly_q << 1;
        dly_d[0] = a;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dly_q <= '1;
        end else begin
            dly_q <= dly_d;
        end
    end

    assign exp_bit  = dly_q[LATENCY-1];
    assign mismatch = q ^ exp_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fill_cnt_q  <= '0;
            match_cnt_q <= '0;
            err_q       <= 1'b0;
            locked_q    <= 1'b0;
            err_count_q <= '0;
        end else if (!en) begin
            // Dropping en discards this cycle's compare result entirely.
            state_q     <= IDLE;
            fill_cnt_q  <= '0;
            match_cnt_q <= '0;
            err_q       <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    state_q    <= FILL;
                    fill_cnt_q <= '0;
                    locked_q   <= 1'b0;
                end
                FILL: begin
                    if (fill_cnt_q == FILL_LAST) begin
                        state_q     <= CHECK;
                        match_cnt_q <= '0;
                    end else begin
                        fill_cnt_q <= fill_cnt_q + 1'b1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_q       <= 1'b1;
                        match_cnt_q <= '0;
                        if (err_count_q != '1) begin
                            err_count_q <= err_count_q + 1'b1;
                        end
                    end else if (match_cnt_q == MATCH_LAST) begin
                        state_q     <= LOCKED;
                        locked_q    <= 1'b1;
                        match_cnt_q <= match_cnt_q + 1'b1;
                    end else begin
                        match_cnt_q <= match_cnt_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (mismatch) begin
                        state_q     <= CHECK;
                        locked_q    <= 1'b0;
                        err_q       <= 1'b1;
                        match_cnt_q <= '0;
                        if (err_count_q != '1) begin
                            err_count_q <= err_count_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign locked     = locked_q;
    assign err        = err_q;
    assign err_count  = err_count_q;
    assign dbg_o.state = state_q;
    assign dbg_o.lfsr  = lfsr;

endmodule

// File: tb/tb_global_prbs_tester.sv
// Directed bench for global_prbs_tester: register-chain loopback model, fault injection,
// enable toggling and error-counter saturation on a narrow-counter instance.
module tb_global_prbs_tester;
    import global_test_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        en_sat;
    logic        inv;
    int          chain_len;
    logic [7:0]  chain_q = '1;
    logic        q;
    logic        a;
    logic        locked;
    logic        err;
    logic [15:0] err_count;
    dbg_t        dbg;

    logic        a_sat;
    logic        q_sat;
    logic        locked_sat;
    logic        err_sat;
    logic [3:0]  err_count_sat;
    dbg_t        dbg_sat;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    // First 16 PRBS7 output bits from seed 7'h7F, index 0 in the MSB.
    logic [15:0] prbs_head = 16'b1111_1110_0000_0100;

    always #5 clk = ~clk;

    // Behavioural register chain: q is a delayed by chain_len flops, optionally inverted.
    always @(posedge clk) chain_q <= {chain_q[6:0], a};
    assign q     = chain_q[chain_len-1] ^ inv;
    assign q_sat = 1'b0;

    global_prbs_tester dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .a         (a),
        .q         (q),
        .locked    (locked),
        .err       (err),
        .err_count (err_count),
        .dbg_o     (dbg)
    );

    global_prbs_tester #(.ERR_W(4)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .en        (en_sat),
        .a         (a_sat),
        .q         (q_sat),
        .locked    (locked_sat),
        .err       (err_sat),
        .err_count (err_count_sat),
        .dbg_o     (dbg_sat)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic push_head(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({31'd0, prbs_head[15-i]});
        end
    endtask

    task automatic check_a_next(input string tag);
        logic [31:0] e;
        e = exp_q.pop_front();
        check(tag, {31'd0, a}, e);
    endtask

    initial begin
        int bad;
        int lk_bad;
        int err_bad;
        int lock_seen;
        int wraps;
        int sat_pulses;
        logic [15:0] mid_cnt;
        logic [15:0] saved_cnt;
        logic [3:0]  prev_sat;

        rst = 1'b1; en = 1'b0; en_sat = 1'b0; inv = 1'b0; chain_len = 5;

        // Reset
        repeat (3) @(negedge clk);
        check("rst_a", {31'd0, a}, 1);
        check("rst_locked", {31'd0, locked}, 0);
        check("rst_err", {31'd0, err}, 0);
        check("rst_err_count", {16'd0, err_count}, 0);
        check("rst_state", 32'(dbg.state), 32'(IDLE));
        check("rst_sat_count", {28'd0, err_count_sat}, 0);
        rst = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (a !== 1'b1) bad++;
        end
        check("idle_a_hold", bad, 0);

        // Clean 5-stage loopback
        push_head(16);
        en = 1'b1;
        lk_bad = 0; err_bad = 0;
        for (int k = 0; k <= 1037; k++) begin
            @(negedge clk);
            if (k < 16) check_a_next("clean_a_seq");
            if (k == 36) check("clean_locked_e36", {31'd0, locked}, 0);
            if (k == 37) check("clean_locked_e37", {31'd0, locked}, 1);
            if (k > 37 && locked !== 1'b1) lk_bad++;
            if (err !== 1'b0) err_bad++;
        end
        check("clean_lock_hold", lk_bad, 0);
        check("clean_no_err", err_bad, 0);
        check("clean_err_count", {16'd0, err_count}, 0);

        // Single inverted q while locked
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
        check("inv_err", {31'd0, err}, 1);
        check("inv_locked_drop", {31'd0, locked}, 0);
        check("inv_err_count", {16'd0, err_count}, 1);
        check("inv_state", 32'(dbg.state), 32'(CHECK));
        @(negedge clk);
        check("inv_err_one_cycle", {31'd0, err}, 0);
        repeat (30) @(negedge clk);
        check("relock_e31", {31'd0, locked}, 0);
        @(negedge clk);
        check("relock_e32", {31'd0, locked}, 1);

        // Chain one stage short: never locks, errors accumulate
        en = 1'b0;
        @(negedge clk);
        check("dis_state", 32'(dbg.state), 32'(IDLE));
        chain_len = 4;
        en = 1'b1;
        lock_seen = 0;
        mid_cnt = '0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (locked) lock_seen++;
            if (k == 150) mid_cnt = err_count;
        end
        check("short_never_lock", lock_seen, 0);
        check("short_err_grows", {31'd0, (err_count > mid_cnt)}, 1);
        check("short_err_many", {31'd0, (err_count >= 16'd50)}, 1);

        // en low at edge 50, high again at edge 60
        en = 1'b0;
        @(negedge clk);
        chain_len = 5;
        saved_cnt = err_count;
        en = 1'b1;
        for (int k = 0; k <= 49; k++) begin
            @(negedge clk);
            if (k == 37) check("tog_locked_first", {31'd0, locked}, 1);
        end
        en = 1'b0;
        @(negedge clk);
        check("tog_idle_state", 32'(dbg.state), 32'(IDLE));
        check("tog_idle_a", {31'd0, a}, 1);
        check("tog_idle_locked", {31'd0, locked}, 0);
        check("tog_idle_count", {16'd0, err_count}, {16'd0, saved_cnt});
        repeat (9) @(negedge clk);
        push_head(8);
        en = 1'b1;
        for (int k = 0; k <= 37; k++) begin
            @(negedge clk);
            if (k < 8) check_a_next("tog_a_restart");
            if (k == 36) check("tog_locked_e36", {31'd0, locked}, 0);
            if (k == 37) check("tog_locked_e37", {31'd0, locked}, 1);
        end
        check("tog_count_kept", {16'd0, err_count}, {16'd0, saved_cnt});

        // Mismatch on the LOCK_COUNT-th compare
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        for (int k = 0; k <= 36; k++) @(negedge clk);
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
        check("edge_lock_err", {31'd0, err}, 1);
        check("edge_lock_locked", {31'd0, locked}, 0);
        check("edge_lock_state", 32'(dbg.state), 32'(CHECK));
        check("edge_lock_count", {16'd0, err_count}, {16'd0, saved_cnt} + 1);
        repeat (31) @(negedge clk);
        check("edge_relock_e68", {31'd0, locked}, 0);
        @(negedge clk);
        check("edge_relock_e69", {31'd0, locked}, 1);

        // rst mid-run overrides en
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_count", {16'd0, err_count}, 0);
        check("mid_rst_locked", {31'd0, locked}, 0);
        check("mid_rst_a", {31'd0, a}, 1);
        check("mid_rst_state", 32'(dbg.state), 32'(IDLE));
        push_head(8);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_a_next("mid_rst_a_seq");
        end

        // Stuck-at-0 response on the 4-bit counter instance
        en_sat = 1'b1;
        wraps = 0; sat_pulses = 0;
        prev_sat = err_count_sat;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (err_count_sat < prev_sat) wraps++;
            if (prev_sat == 4'hF && err_sat) sat_pulses++;
            prev_sat = err_count_sat;
        end
        check("sat_count", {28'd0, err_count_sat}, 15);
        check("sat_no_wrap", wraps, 0);
        check("sat_err_pulses", {31'd0, (sat_pulses > 0)}, 1);
        check("sat_never_locked", {31'd0, locked_sat}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
